// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked frame, ACK check.
// Optional macro PS2_TX_GLITCH_FILTER_EN adds an 8-sample debounce on the synchronized PS2Clk.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned START_TIMEOUT  = 1500000,
  parameter int unsigned BIT_TIMEOUT    = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       tx_active,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);
  localparam int unsigned MAX_A   = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int unsigned CNT_MAX = (MAX_A > BIT_TIMEOUT) ? MAX_A : BIT_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned FRAME_W = 11;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, limit;
  logic [FRAME_W-1:0] sh, sh_nxt;
  logic [IDX_W-1:0]   bit_idx, bit_idx_nxt;
  logic               ack_reg, ack_reg_nxt, abort;
  logic               clk_s1, data_s1, sync_clk, sync_data, prev_clk, fall;
  logic               tx_ready_nxt, clk_dl_nxt, data_dl_nxt, active_nxt;
  logic               done_nxt, ack_ok_nxt, err_nxt;

  // Input synchronizers; idle-high reset so no spurious fall after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1    <= 1'b1;
      data_s1   <= 1'b1;
      sync_data <= 1'b1;
      prev_clk  <= 1'b1;
    end else begin
      clk_s1    <= ps2_clk_in;
      data_s1   <= ps2_data_in;
      sync_data <= data_s1;
      prev_clk  <= sync_clk;
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic       clk_s2;
  logic [2:0] flt_cnt;

  // sync_clk follows clk_s2 only after 8 consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s2   <= 1'b1;
      flt_cnt  <= 3'd0;
      sync_clk <= 1'b1;
    end else begin
      clk_s2 <= clk_s1;
      if (clk_s2 == sync_clk) begin
        flt_cnt <= 3'd0;
      end else if (flt_cnt == 3'd7) begin
        sync_clk <= clk_s2;
        flt_cnt  <= 3'd0;
      end else begin
        flt_cnt <= flt_cnt + 3'd1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) sync_clk <= 1'b1;
    else     sync_clk <= clk_s1;
  end
`endif

  assign fall = prev_clk & ~sync_clk;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath; a fall always beats a coincident timeout
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    sh_nxt      = sh;
    bit_idx_nxt = bit_idx;
    ack_reg_nxt = ack_reg;
    abort       = 1'b0;
    limit       = (bit_idx == IDX_W'(0)) ? CNT_W'(START_TIMEOUT - 1) : CNT_W'(BIT_TIMEOUT - 1);
    unique case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (tx_valid) begin
          sh_nxt      = {1'b1, ~^tx_data, tx_data, 1'b0};
          bit_idx_nxt = '0;
          ack_reg_nxt = 1'b0;
          state_nxt   = S_INHIBIT;
        end
      end
      S_INHIBIT: if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) state_nxt = S_REQ;
      S_REQ: begin
        cnt_nxt   = '0;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        if (fall) begin
          cnt_nxt     = '0;
          sh_nxt      = {1'b1, sh[FRAME_W-1:1]};
          bit_idx_nxt = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_W'(9)) state_nxt = S_ACK;
        end else if (cnt == limit) begin
          abort = 1'b1;
        end
      end
      S_ACK: begin
        if (fall) begin
          cnt_nxt     = '0;
          ack_reg_nxt = ~sync_data;
          state_nxt   = S_WAIT_IDLE;
        end else if (cnt == limit) begin
          abort = 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (sync_clk & sync_data) state_nxt = S_DONE;
        else if (fall)            cnt_nxt = '0;
        else if (cnt == limit)    abort = 1'b1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    tx_ready_nxt = 1'b0;
    clk_dl_nxt   = 1'b0;
    data_dl_nxt  = 1'b0;
    active_nxt   = 1'b1;
    done_nxt     = 1'b0;
    ack_ok_nxt   = 1'b0;
    err_nxt      = abort;
    unique case (state_nxt)
      S_IDLE: begin
        tx_ready_nxt = 1'b1;
        active_nxt   = 1'b0;
      end
      S_INHIBIT: clk_dl_nxt = 1'b1;
      S_REQ: begin
        clk_dl_nxt  = 1'b1;
        data_dl_nxt = 1'b1;
      end
      S_SEND: data_dl_nxt = ~sh_nxt[0];
      S_DONE: begin
        done_nxt   = 1'b1;
        ack_ok_nxt = ack_reg_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt                <= '0;
      sh                 <= '0;
      bit_idx            <= '0;
      ack_reg            <= 1'b0;
      tx_ready           <= 1'b1;
      ps2_clk_drive_low  <= 1'b0;
      ps2_data_drive_low <= 1'b0;
      tx_active          <= 1'b0;
      done               <= 1'b0;
      ack_ok             <= 1'b0;
      err_timeout        <= 1'b0;
    end else begin
      cnt                <= cnt_nxt;
      sh                 <= sh_nxt;
      bit_idx            <= bit_idx_nxt;
      ack_reg            <= ack_reg_nxt;
      tx_ready           <= tx_ready_nxt;
      ps2_clk_drive_low  <= clk_dl_nxt;
      ps2_data_drive_low <= data_dl_nxt;
      tx_active          <= active_nxt;
      done               <= done_nxt;
      ack_ok             <= ack_ok_nxt;
      err_timeout        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model plus a behavioural PS/2 device.
// Scaled-down timing parameters keep the run short.
module tb_ps2_host_tx;
  localparam int unsigned T_INH   = 40;
  localparam int unsigned T_START = 600;
  localparam int unsigned T_BIT   = 300;
  localparam int unsigned HALF    = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, clk_dl, data_dl, tx_active, done, ack_ok, err_timeout;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       clk_line, data_line;

  int tests = 0, fails = 0;

  // Per-frame observations
  logic [9:0] got;
  logic       start_bit, ack_seen;
  int         inh, req, done_cnt, err_cnt, err_at, bad_idle;

  assign clk_line  = dev_clk & ~clk_dl;
  assign data_line = dev_data & ~data_dl;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(T_INH),
    .START_TIMEOUT (T_START),
    .BIT_TIMEOUT   (T_BIT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .tx_valid          (tx_valid),
    .tx_data           (tx_data),
    .tx_ready          (tx_ready),
    .ps2_clk_in        (clk_line),
    .ps2_data_in       (data_line),
    .ps2_clk_drive_low (clk_dl),
    .ps2_data_drive_low(data_dl),
    .tx_active         (tx_active),
    .done              (done),
    .ack_ok            (ack_ok),
    .err_timeout       (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] d);
    @(negedge clk);
    check("ready_before_send", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_request();
    int w = 0;
    while (!(clk_line && !data_line) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("request_seen", 32'(w < 2000), 32'd1);
  endtask

  // Device: 11 clock pulses, samples host data while clock is high, optional ACK on the 11th
  task automatic device(input bit acks, input bit glitch, input logic [7:0] d);
    got = 'x;
    wait_request();
    start_bit = data_line;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      if (k == 10 && acks) begin
        dev_data = 1'b0;
        repeat (5) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (k < 10) got[k] = data_line;
      if (k == 4) begin
        tx_valid = 1'b1;
        tx_data  = ~d;
      end
      @(negedge clk);
      tx_valid = 1'b0;
      if (glitch && k == 3) begin
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF - 9) @(negedge clk);
      end else begin
        repeat (HALF - 1) @(negedge clk);
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic monitor();
    bit released = 1'b0, seen_drive = 1'b0;
    int rel = 0, post = 0;
    inh = 0; req = 0; done_cnt = 0; err_cnt = 0; err_at = -1; bad_idle = 0; ack_seen = 1'bx;
    for (int c = 0; c < 4000 && post < 60; c++) begin
      @(negedge clk);
      if (!released && seen_drive && !clk_dl) begin
        released = 1'b1;
        rel      = 0;
      end
      if (clk_dl) seen_drive = 1'b1;
      if (clk_dl && !data_dl) inh++;
      if (clk_dl && data_dl)  req++;
      if (post >= 1 && (tx_active || !tx_ready || clk_dl || data_dl || done || err_timeout)) bad_idle++;
      if (done) begin
        done_cnt++;
        ack_seen = ack_ok;
      end
      if (err_timeout) begin
        if (err_cnt == 0) err_at = rel;
        err_cnt++;
      end
      if (done_cnt + err_cnt > 0) post++;
      if (released) rel++;
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input bit clocks, input bit acks, input bit glitch);
    logic par;
    par = (($countones(d) % 2) == 0);
    fork
      begin
        issue(d);
        if (clocks) device(acks, glitch, d);
      end
      monitor();
    join
    check("inhibit_cycles", 32'(inh), 32'(T_INH));
    check("request_cycles", 32'(req), 32'd1);
    check("idle_after_frame", 32'(bad_idle), 32'd0);
    if (clocks) begin
      check("start_bit", 32'(start_bit), 32'd0);
      check("frame_bits", 32'(got), 32'({1'b1, par, d}));
      check("done_pulses", 32'(done_cnt), 32'd1);
      check("ack_ok", 32'(ack_seen), 32'(acks));
      check("no_timeout", 32'(err_cnt), 32'd0);
    end else begin
      check("timeout_cycle", 32'(err_at), 32'(T_START));
      check("timeout_pulses", 32'(err_cnt), 32'd1);
      check("no_done_on_abort", 32'(done_cnt), 32'd0);
    end
  endtask

  task automatic reset_mid_frame(input logic [7:0] d);
    int bad = 0;
    issue(d);
    wait_request();
    repeat (HALF) @(negedge clk);
    repeat (4) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    check("active_before_rst", 32'(tx_active), 32'd1);
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hF4;
    @(negedge clk);
    rst      = 1'b0;
    tx_valid = 1'b0;
    check("rst_lines_released", 32'({clk_dl, data_dl}), 32'd0);
    check("rst_ready_idle", 32'({tx_ready, tx_active}), 32'b10);
    repeat (100) begin
      @(negedge clk);
      if (tx_active || !tx_ready || clk_dl || data_dl || done || err_timeout) bad++;
    end
    check("rst_quiet", 32'(bad), 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    bit         ra;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    // Idle with device clock toggling: nothing may happen
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      dev_clk = ((i / 8) % 2 == 1) ? 1'b0 : 1'b1;
      check("idle_outputs", 32'({tx_ready, tx_active, clk_dl, data_dl, done, ack_ok, err_timeout}), 32'b1000000);
    end
    dev_clk = 1'b1;
    repeat (10) @(negedge clk);

    run_frame(8'hF4, 1'b1, 1'b1, 1'b0);
    run_frame(8'hED, 1'b1, 1'b0, 1'b0);
    run_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    reset_mid_frame(8'hA5);
    for (int n = 0; n < 4; n++) begin
      rd = 8'($urandom);
      ra = 1'($urandom);
      run_frame(rd, 1'b1, ra, 1'b0);
    end
`ifdef PS2_TX_GLITCH_FILTER_EN
    run_frame(8'hF4, 1'b1, 1'b1, 1'b1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
